// File: rtl/nibble_serial_subtractor.sv
// ============================================================================
// Module   : nibble_serial_subtractor
// Brief    : WIDTH-bit subtractor, one borrow-lookahead nibble per clock.
// Revision : 1.0
// ============================================================================
`default_nettype none

module nibble_serial_subtractor #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic             overflow,
    output logic             zero
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int IW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] c_LAST = IW'(NIBBLES - 1);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_RUN  = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_next_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_part;
    logic             r_borrow;
    logic [IW-1:0]    r_idx;
    logic             r_done;
    logic [WIDTH-1:0] r_diff;
    logic             r_b_out;
    logic             r_overflow;
    logic             r_zero;

    logic [3:0]       w_a;
    logic [3:0]       w_b;
    logic [3:0]       w_p;
    logic [3:0]       w_g;
    logic [4:0]       w_bor;
    logic [3:0]       w_d;
    logic             w_last;
    logic [WIDTH-1:0] w_result;

    // Borrow-lookahead slice on the low nibble of the shifting operand registers
    always_comb begin
        w_a      = r_a[3:0];
        w_b      = r_b[3:0];
        w_p      = ~(w_a ^ w_b);
        w_g      = ~w_a & w_b;
        w_bor[0] = r_borrow;
        w_bor[1] = w_g[0] | (w_p[0] & r_borrow);
        w_bor[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & r_borrow);
        w_bor[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                 | (w_p[2] & w_p[1] & w_p[0] & r_borrow);
        w_bor[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                 | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                 | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & r_borrow);
        w_d      = w_a ^ w_b ^ w_bor[3:0];
        w_last   = (r_idx == c_LAST);
        w_result = {w_d, r_part[WIDTH-1:4]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (start) w_next_state = c_RUN;
            c_RUN:   if (w_last) w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        busy     = (r_state == c_RUN);
        done     = r_done;
        diff     = r_diff;
        b_out    = r_b_out;
        overflow = r_overflow;
        zero     = r_zero;
    end

    // Result nibbles enter at the top so nibble 0 lands at bit 0 after the last shift
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a        <= '0;
            r_b        <= '0;
            r_part     <= '0;
            r_borrow   <= 1'b0;
            r_idx      <= '0;
            r_done     <= 1'b0;
            r_diff     <= '0;
            r_b_out    <= 1'b0;
            r_overflow <= 1'b0;
            r_zero     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == c_IDLE) begin
                if (start) begin
                    r_a      <= in1;
                    r_b      <= in2;
                    r_borrow <= b_in;
                    r_idx    <= '0;
                    r_part   <= '0;
                end
            end else begin
                r_a      <= r_a >> 4;
                r_b      <= r_b >> 4;
                r_borrow <= w_bor[4];
                r_part   <= w_result;
                r_idx    <= r_idx + 1'b1;
                if (w_last) begin
                    r_idx      <= '0;
                    r_diff     <= w_result;
                    r_b_out    <= w_bor[4];
                    r_overflow <= w_bor[3] ^ w_bor[4];
                    r_zero     <= (w_result == '0);
                    r_done     <= 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_subtractor.sv
// ============================================================================
// Module   : tb_nibble_serial_subtractor
// Brief    : Directed self-checking bench for nibble_serial_subtractor.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_nibble_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        b_in;
    logic        busy;
    logic        done;
    logic [31:0] diff;
    logic        b_out;
    logic        overflow;
    logic        zero;

    int checks   = 0;
    int failures = 0;

    nibble_serial_subtractor #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in1      (in1),
        .in2      (in2),
        .b_in     (b_in),
        .busy     (busy),
        .done     (done),
        .diff     (diff),
        .b_out    (b_out),
        .overflow (overflow),
        .zero     (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Presents an operation for one edge; returns #1 after that edge.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic bi);
        @(negedge clk);
        in1   = a;
        in2   = b;
        b_in  = bi;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        in1   = ~a;
        in2   = ~b;
        b_in  = ~bi;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    // Waits for done, checking outputs hold and busy stays high meanwhile.
    task automatic wait_done(input string tag, input int exp_lat, input logic [31:0] hold);
        int  lat;
        bit  held;
        lat  = 0;
        held = 1'b1;
        while (1) begin
            @(posedge clk);
            #1;
            lat++;
            if (done === 1'b1) break;
            if (diff !== hold || busy !== 1'b1) held = 1'b0;
            if (lat >= 40) break;
        end
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_hold_during_run"}, {31'd0, held}, 32'd1);
    endtask

    task automatic chk_res(input string tag, input logic [31:0] d, input logic bo,
                           input logic ov, input logic z);
        chk({tag, "_diff"}, diff, d);
        chk({tag, "_b_out"}, {31'd0, b_out}, {31'd0, bo});
        chk({tag, "_overflow"}, {31'd0, overflow}, {31'd0, ov});
        chk({tag, "_zero"}, {31'd0, zero}, {31'd0, z});
        chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic done_drops(input string tag);
        @(posedge clk);
        #1;
        chk({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        bit seen_done;
        rst   = 1'b1;
        start = 1'b0;
        in1   = '0;
        in2   = '0;
        b_in  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_diff", diff, 32'd0);
        chk("reset_flags", {29'd0, b_out, overflow, zero}, 32'd0);

        // Reset must win over a simultaneous start
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_wins_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;

        // 1: simple subtraction with latency and busy window
        start_op(32'h0000_0005, 32'h0000_0003, 1'b0);
        wait_done("t1", 8, 32'h0);
        chk_res("t1", 32'h0000_0002, 1'b0, 1'b0, 1'b0);
        done_drops("t1");

        // 2: full-width borrow and multi-nibble borrow propagation
        start_op(32'h0000_0000, 32'h0000_0001, 1'b0);
        wait_done("t2a", 8, 32'h0000_0002);
        chk_res("t2a", 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        done_drops("t2a");
        start_op(32'h0001_0000, 32'h0000_0001, 1'b0);
        wait_done("t2b", 8, 32'hFFFF_FFFF);
        chk_res("t2b", 32'h0000_FFFF, 1'b0, 1'b0, 1'b0);

        // 3: signed overflow in both directions
        start_op(32'h8000_0000, 32'h0000_0001, 1'b0);
        wait_done("t3a", 8, 32'h0000_FFFF);
        chk_res("t3a", 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
        start_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_done("t3b", 8, 32'h7FFF_FFFF);
        chk_res("t3b", 32'h8000_0000, 1'b1, 1'b1, 1'b0);

        // 4: zero flag and borrow-in
        start_op(32'h1234_5678, 32'h1234_5678, 1'b0);
        wait_done("t4a", 8, 32'h8000_0000);
        chk_res("t4a", 32'h0000_0000, 1'b0, 1'b0, 1'b1);
        start_op(32'h1234_5678, 32'h1234_5678, 1'b1);
        wait_done("t4b", 8, 32'h0000_0000);
        chk_res("t4b", 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);

        // 5: start ignored while busy, accepted during the done cycle
        start_op(32'h0000_0009, 32'h0000_0004, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        in1   = 32'h0000_0001;
        in2   = 32'h0000_0002;
        b_in  = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("t5a", 5, 32'hFFFF_FFFF);
        chk_res("t5a", 32'h0000_0005, 1'b0, 1'b0, 1'b0);
        in1   = 32'h0000_0001;
        in2   = 32'h0000_0002;
        b_in  = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("t5b_busy_accept", {31'd0, busy}, 32'd1);
        chk("t5b_done_low", {31'd0, done}, 32'd0);
        wait_done("t5b", 8, 32'h0000_0005);
        chk_res("t5b", 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);

        // 6: reset mid-run aborts with no done pulse
        start_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_done", {31'd0, done}, 32'd0);
        chk("t6_diff", diff, 32'd0);
        chk("t6_flags", {29'd0, b_out, overflow, zero}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen_done = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0 || busy !== 1'b0) seen_done = 1'b1;
        end
        chk("t6_no_done_after_abort", {31'd0, seen_done}, 32'd0);
        start_op(32'h0000_0010, 32'h0000_0001, 1'b0);
        wait_done("t6b", 8, 32'h0000_0000);
        chk_res("t6b", 32'h0000_000F, 1'b0, 1'b0, 1'b0);
        done_drops("t6b");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/nibble_serial_subtractor.md
Name: nibble_serial_subtractor

Overview:
Multi-cycle WIDTH-bit subtractor. Computes in1 − in2 − b_in one 4-bit nibble per clock, least-significant nibble first. Each nibble uses a 4-bit borrow-lookahead slice, the borrow-domain counterpart of the team's carry-lookahead adder slices. It sits beside the CLA adders in the ALU datapath as the area-lean subtract/compare unit, with a start/busy/done handshake.

Parameters:
WIDTH, 32, operand width in bits; must be a multiple of 4 and at least 8.
NIBBLES, WIDTH/4, derived; the number of RUN cycles. Not to be overridden.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
start  input  1  request; sampled only in IDLE
in1  input  WIDTH  minuend; sampled with start
in2  input  WIDTH  subtrahend; sampled with start
b_in  input  1  borrow-in; sampled with start
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when results update
diff  output  WIDTH  in1 − in2 − b_in, mod 2^WIDTH
b_out  output  1  borrow out of the MSB (1 = unsigned in1 < in2 + b_in)
overflow  output  1  two's-complement overflow of the subtraction
zero  output  1  diff == 0

Behaviour:
- Reset (rst high at a clock edge): state IDLE; busy, done, diff, b_out, overflow and zero all 0. Internal operand, partial-result, borrow and index registers also clear. Reset wins over start in the same cycle. Reset mid-RUN aborts the operation: no done pulse, and no partial result ever appears on the outputs.
- States: IDLE, RUN.
- IDLE:
  - start=1 at edge t0: latch in1, in2 and b_in; borrow register ← b_in; nibble index k ← 0; go to RUN; busy=1 from t0 onward.
  - start=0: remain in IDLE.
- RUN, nibble k processed at edge t0+1+k, for k = 0..NIBBLES−1:
  - With a = in1 nibble k, b = in2 nibble k, bi = borrow register:
    - bit propagate P[j] = ~(a[j]^b[j])
    - bit generate G[j] = ~a[j] & b[j]
    - bit borrow: bor[0] = bi; bor[j+1] = G[j] | (P[j] & bor[j]), expanded in lookahead form with no ripple between bits
    - difference bit d[j] = a[j] ^ b[j] ^ bor[j]
  - Write d into partial-result nibble k; borrow register ← bor[4].
- Completion, at edge t0+NIBBLES (the last nibble):
  - diff ← full partial result.
  - b_out ← final bor[4].
  - overflow ← (borrow into the MSB) XOR (borrow out of the MSB).
  - zero ← (full result == 0).
  - busy ← 0; done ← 1 for exactly one cycle; state ← IDLE.
- Latency: done is visible NIBBLES cycles after start is sampled (8 for WIDTH=32). Throughput is one operation per NIBBLES+1 cycles at best.
- diff, b_out, overflow and zero hold the last completed result until the next completion edge; they do not change during RUN.
- start while busy=1 is ignored: no queuing, and the latched operands are unaffected.
- start in the same cycle as done=1 (state is IDLE) is accepted. Outputs still show the previous result until the new completion.
- Operands may change freely after the start edge.

Test Plan:
1. WIDTH=32, in1=0x00000005, in2=0x00000003, b_in=0 -> after 8 cycles done=1 for one cycle; diff=0x00000002, b_out=0, overflow=0, zero=0; busy high for exactly the 8 cycles in between.
2. in1=0x00000000, in2=0x00000001, b_in=0 -> diff=0xFFFFFFFF, b_out=1, overflow=0. Then in1=0x00010000, in2=0x00000001 -> diff=0x0000FFFF, b_out=0 (borrow propagates across 4 nibbles).
3. in1=0x80000000, in2=0x00000001 -> diff=0x7FFFFFFF, overflow=1, b_out=0. Then in1=0x7FFFFFFF, in2=0xFFFFFFFF -> diff=0x80000000, overflow=1, b_out=1.
4. in1=in2=0x12345678, b_in=0 -> diff=0, zero=1, b_out=0. Same operands with b_in=1 -> diff=0xFFFFFFFF, zero=0, b_out=1.
5. Start op A (9−4), pulse start with op B (1−2) at cycle 3 -> op B ignored, diff=0x00000005. Then hold start with op B asserted during the done cycle -> op B accepted; its done arrives 8 cycles later with diff=0xFFFFFFFF, and outputs hold 0x00000005 until then.
6. Start 0xFFFFFFFF−0x1, assert rst at cycle 4 -> next cycle busy=0, done=0, diff=0, b_out=0, overflow=0, zero=0, no done pulse afterwards. A subsequent start of 0x10−0x1 yields diff=0x0000000F.
